// File: rtl/dm_access_arbiter.sv
// Purpose : shares one single-port data memory between port 0 (SPI engine) and port 1 (local/debug host)
// Latency : request seen in IDLE at cycle N -> memory access in N+1 -> ack pulse in N+2; one access per 3 cycles
// Backpres: requesters hold req and fields until ack; a port-0 lock starves port 1 for at most LOCK_MAX cycles
//
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   p0_*/p1_* req,we,addr,wdata   level request and access fields per requester
//   p0_lock                       port 0 claims the memory for its whole chip-select window
//   p0_ack/p1_ack, p0_rdata/...   completion pulse, read data held until the next ack on that port
//   mem_addr/mem_din/mem_we/dout  data memory (combinational read, posedge write)
//   owner, locked, lock_timeout   grant/lock status
module dm_access_arbiter #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int LOCK_MAX   = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic                  p0_lock,
   output logic                  p0_ack,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_ack,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  owner,
   output logic                  locked,
   output logic                  lock_timeout
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] ACK    = 2'd2;

   logic [1:0]       state;
   logic             we_q;
   logic             last_grant;
   logic [CNT_W-1:0] lock_cnt;

   logic cnt_full;
   logic p1_elig;
   logic any_req;
   logic override;
   logic grant_go;
   logic win;

   // Port 1 is shut out while locked unless the lock has been held against it
   // for LOCK_MAX cycles; lock_cnt is only nonzero while locked.
   assign cnt_full = (lock_cnt == CNT_MAX);
   assign p1_elig  = p1_req && (!locked || cnt_full);
   assign any_req  = p0_req || p1_elig;
   assign grant_go = (state == IDLE) && any_req;
   assign override = grant_go && cnt_full && p1_req;

   always_comb begin
      win = 1'b0;
      if (override)
         win = 1'b1;
      else if (p0_req && p1_elig)
         win = ~last_grant;        // round robin on a tie
      else
         win = p1_elig;
   end

   // Write strobe lives only in ACCESS, so a write is exactly one cycle wide
   // and a reset sampled during ACCESS still lets the memory commit it.
   assign mem_we = (state == ACCESS) && we_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= '0;
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         p0_ack       <= 1'b0;
         p1_ack       <= 1'b0;
         p0_rdata     <= '0;
         p1_rdata     <= '0;
         locked       <= 1'b0;
         lock_cnt     <= '0;
         lock_timeout <= 1'b0;
      end else begin
         p0_ack       <= 1'b0;
         p1_ack       <= 1'b0;
         lock_timeout <= override;

         case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= ACCESS;
                  owner    <= win;
                  we_q     <= win ? p1_we    : p0_we;
                  mem_addr <= win ? p1_addr  : p0_addr;
                  mem_din  <= win ? p1_wdata : p0_wdata;
               end
            end
            ACCESS: begin
               state <= ACK;
               if (!we_q) begin
                  if (owner)
                     p1_rdata <= mem_dout;
                  else
                     p0_rdata <= mem_dout;
               end
               // registered here so the pulse is visible during ACK
               p0_ack <= ~owner;
               p1_ack <= owner;
            end
            ACK: begin
               state      <= IDLE;
               last_grant <= owner;
            end
            default: state <= IDLE;
         endcase

         // Lock only engages on a port-0 win; a port-1 win in the same cycle
         // as the lock rise leaves it disengaged until port 0 next wins.
         if (!p0_lock)
            locked <= 1'b0;
         else if (grant_go && !win)
            locked <= 1'b1;

         if (!p0_lock || !locked)
            lock_cnt <= '0;
         else if (override)
            lock_cnt <= '0;
         else if (p1_req && !cnt_full)
            lock_cnt <= lock_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter: instance a uses LOCK_MAX=64, instance b uses LOCK_MAX=8.
// Both instances see the same stimulus, each with its own memory model.
module tb_dm_access_arbiter;

   localparam int AW = 7;
   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic          p0_req, p1_req, p0_we, p1_we, p0_lock;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;

   logic          a_p0_ack, a_p1_ack, a_mem_we, a_owner, a_locked, a_lock_timeout;
   logic [DW-1:0] a_p0_rdata, a_p1_rdata, a_mem_din, a_mem_dout;
   logic [AW-1:0] a_mem_addr;
   logic          b_p0_ack, b_p1_ack, b_mem_we, b_owner, b_locked, b_lock_timeout;
   logic [DW-1:0] b_p0_rdata, b_p1_rdata, b_mem_din, b_mem_dout;
   logic [AW-1:0] b_mem_addr;

   logic [DW-1:0] mem_a [0:127];
   logic [DW-1:0] mem_b [0:127];

   int total = 0;
   int bad   = 0;
   int pulses;
   logic [4:0] seq;

   dm_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(64)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
      .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
      .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_we(a_mem_we), .mem_dout(a_mem_dout),
      .owner(a_owner), .locked(a_locked), .lock_timeout(a_lock_timeout)
   );

   dm_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(8)) dut8 (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
      .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
      .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_we(b_mem_we), .mem_dout(b_mem_dout),
      .owner(b_owner), .locked(b_locked), .lock_timeout(b_lock_timeout)
   );

   assign a_mem_dout = mem_a[a_mem_addr];
   assign b_mem_dout = mem_b[b_mem_addr];

   always @(posedge clk) begin
      if (a_mem_we) mem_a[a_mem_addr] <= a_mem_din;
      if (b_mem_we) mem_b[b_mem_addr] <= b_mem_din;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0; p0_lock = 0;
      p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
      tick; tick;
      reset = 1'b0;

      // reset values
      chk("rst_p0_ack", a_p0_ack, 0);
      chk("rst_p1_ack", a_p1_ack, 0);
      chk("rst_p0_rdata", a_p0_rdata, 0);
      chk("rst_p1_rdata", a_p1_rdata, 0);
      chk("rst_mem_addr", a_mem_addr, 0);
      chk("rst_mem_din", a_mem_din, 0);
      chk("rst_mem_we", a_mem_we, 0);
      chk("rst_owner", a_owner, 0);
      chk("rst_locked", a_locked, 0);
      chk("rst_lock_timeout", a_lock_timeout, 0);

      // single write by port 0
      p0_req = 1; p0_we = 1; p0_addr = 7'h10; p0_wdata = 8'h5C;
      chk("wr_idle_we", a_mem_we, 0);
      tick;
      chk("wr_we", a_mem_we, 1);
      chk("wr_addr", a_mem_addr, 7'h10);
      chk("wr_din", a_mem_din, 8'h5C);
      chk("wr_owner", a_owner, 0);
      chk("wr_early_ack", a_p0_ack, 0);
      tick;
      chk("wr_ack", a_p0_ack, 1);
      chk("wr_we_one_cycle", a_mem_we, 0);
      chk("wr_p1_ack", a_p1_ack, 0);
      p0_req = 0; p0_we = 0;
      tick;
      chk("wr_ack_pulse", a_p0_ack, 0);

      // port 1 writes A3 to 0x05; a write must not touch p1_rdata
      p1_req = 1; p1_we = 1; p1_addr = 7'h05; p1_wdata = 8'hA3;
      tick;
      chk("wr1_owner", a_owner, 1);
      chk("wr1_we", a_mem_we, 1);
      chk("wr1_addr", a_mem_addr, 7'h05);
      tick;
      chk("wr1_ack", a_p1_ack, 1);
      chk("wr1_rdata_kept", a_p1_rdata, 0);
      p1_req = 0; p1_we = 0;
      tick;

      // single read by port 1
      p1_req = 1;
      tick;
      chk("rd1_we", a_mem_we, 0);
      chk("rd1_addr", a_mem_addr, 7'h05);
      tick;
      chk("rd1_ack", a_p1_ack, 1);
      chk("rd1_rdata", a_p1_rdata, 8'hA3);
      p1_req = 0;
      tick;

      // port 0 reads back its write; port 1 data is held
      p0_req = 1;
      tick;
      tick;
      chk("rd0_ack", a_p0_ack, 1);
      chk("rd0_rdata", a_p0_rdata, 8'h5C);
      chk("rd0_p1_held", a_p1_rdata, 8'hA3);
      p0_req = 0;
      tick;

      // contention after reset: 0,1,0,1, ack every third cycle
      reset = 1; tick; reset = 0;
      p0_req = 1; p1_req = 1;
      for (int i = 0; i < 4; i++) begin
         chk("cont_idle_noack", {a_p0_ack, a_p1_ack}, 0);
         tick;
         chk("cont_owner", a_owner, i % 2);
         tick;
         chk("cont_p0_ack", a_p0_ack, (i % 2) == 0);
         chk("cont_p1_ack", a_p1_ack, (i % 2) == 1);
         tick;
      end

      // lock: port 0 keeps the memory for 4 reads, then port 1 after lock falls
      p0_lock = 1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("lock_owner", a_owner, 0);
         chk("lock_locked", a_locked, 1);
         tick;
         chk("lock_ack", a_p0_ack, 1);
         chk("lock_rdata", a_p0_rdata, 8'h5C);
         if (i == 3) p0_lock = 0;
         tick;
      end
      chk("unlock_locked", a_locked, 0);
      tick;
      chk("unlock_owner", a_owner, 1);
      tick;
      chk("unlock_p1_ack", a_p1_ack, 1);
      p0_req = 0; p1_req = 0;
      tick;

      // lock timeout on the LOCK_MAX=8 instance
      reset = 1; tick; reset = 0;
      p0_lock = 1; p0_req = 1; p1_req = 1;
      seq = 5'b01000;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         chk("to_idle_pulse", b_lock_timeout, 0);
         tick;
         chk("to_owner", b_owner, seq[i]);
         chk("to_pulse", b_lock_timeout, seq[i]);
         chk("to_locked", b_locked, 1);
         pulses += int'(b_lock_timeout);
         tick;
         chk("to_p1_ack", b_p1_ack, seq[i]);
         tick;
      end
      chk("to_pulse_count", pulses, 1);

      // reset during ACCESS of a write
      p0_lock = 0; p0_req = 0; p1_req = 0;
      reset = 1; tick; reset = 0;
      p0_req = 1; p0_we = 0; p0_addr = 7'h10;
      tick;
      tick;
      chk("pre_rst_ack", a_p0_ack, 1);
      chk("pre_rst_rdata", a_p0_rdata, 8'h5C);
      p0_req = 0;
      tick;
      p0_req = 1; p0_we = 1; p0_addr = 7'h20; p0_wdata = 8'h7E;
      tick;
      chk("mid_we", a_mem_we, 1);
      reset = 1; p0_req = 0; p0_we = 0;
      tick;
      chk("mid_ack", a_p0_ack, 0);
      chk("mid_mem_we", a_mem_we, 0);
      chk("mid_mem_addr", a_mem_addr, 0);
      chk("mid_mem_din", a_mem_din, 0);
      chk("mid_rdata", a_p0_rdata, 0);
      chk("mid_owner", a_owner, 0);
      chk("mid_locked", a_locked, 0);
      chk("mid_committed", mem_a[7'h20], 8'h7E);
      reset = 0;
      tick;
      chk("post_ack", a_p0_ack, 0);
      chk("post_we", a_mem_we, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
